// File: rtl/lif_neuron_update.sv
// lif_neuron_update
// Leaky integrate-and-fire membrane stage. Consumes P synaptic current lanes
// per beat and updates the matching neurons' signed membrane potentials
// (leak, integrate, saturate, threshold/reset). After NNEU/P beats it presents
// the timestep's spike bitmap and waits for the downstream handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   syn_ipt           P lanes of signed MWID-bit current, lane j -> neuron base+j
//   syn_ipt_valid     input beat valid
//   syn_ipt_ready     registered; stage accepts a beat
//   v_clr             synchronous clear of membranes and step progress
//   spike_opt         NNEU-bit spike bitmap of the finished timestep
//   spike_opt_valid   registered; spike_opt holds a finished timestep
//   spike_opt_ready   downstream accepts spike_opt
module lif_neuron_update #(
    parameter int unsigned P          = 1,
    parameter int unsigned MWID       = 16,
    parameter int unsigned VWID       = 16,
    parameter int unsigned NNEU       = 32,
    parameter int unsigned LEAK_SHIFT = 4,
    parameter int          VTH        = 1024,
    parameter int          VRST       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [P*MWID-1:0] syn_ipt,
    input  logic              syn_ipt_valid,
    output logic              syn_ipt_ready,
    input  logic              v_clr,
    output logic [NNEU-1:0]   spike_opt,
    output logic              spike_opt_valid,
    input  logic              spike_opt_ready
);

    localparam int unsigned BW = (NNEU > 1) ? $clog2(NNEU) : 1;
    localparam int unsigned SW = VWID + 2;

    localparam logic [BW-1:0]          LAST_BASE = BW'(NNEU - P);
    localparam logic [BW-1:0]          BASE_STEP = BW'(P);
    localparam logic signed [VWID-1:0] VTH_V     = VWID'(VTH);
    localparam logic signed [VWID-1:0] VRST_V    = VWID'(VRST);
    localparam logic signed [SW-1:0]   SMAX      = {3'b000, {(VWID-1){1'b1}}};
    localparam logic signed [SW-1:0]   SMIN      = {3'b111, {(VWID-1){1'b0}}};

    typedef enum logic [0:0] {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [BW-1:0]           base;
    logic signed [VWID-1:0]  v [NNEU];
    logic [NNEU-1:0]         work;
    logic [NNEU-1:0]         work_n;
    logic signed [VWID-1:0]  lane_v [P];
    logic [P-1:0]            lane_spk;
    logic                    accept;
    logic                    last_beat;

    // v_clr discards any beat handshaking in the same cycle
    assign accept    = syn_ipt_valid && syn_ipt_ready && !v_clr;
    assign last_beat = accept && (base == LAST_BASE);

    // Per-lane membrane update: leak, integrate, saturate, threshold
    for (genvar j = 0; j < P; j++) begin : g_lane
        logic [BW-1:0]          idx;
        logic signed [VWID-1:0] vcur;
        logic signed [MWID-1:0] cur;
        logic signed [SW-1:0]   vl;
        logic signed [SW-1:0]   s;
        logic signed [SW-1:0]   s_sat;

        assign idx  = base + BW'(j);
        assign vcur = v[idx];
        assign cur  = syn_ipt[j*MWID +: MWID];
        // Arithmetic shift rounds toward -inf, so leak never overshoots zero
        assign vl   = SW'(vcur) - SW'(vcur >>> LEAK_SHIFT);
        assign s    = vl + SW'(cur);

        always_comb begin
            s_sat = s;
            if (s > SMAX) begin
                s_sat = SMAX;
            end else if (s < SMIN) begin
                s_sat = SMIN;
            end
        end

        assign lane_spk[j] = (s_sat >= SW'(VTH_V));
        assign lane_v[j]   = lane_spk[j] ? VRST_V : VWID'(s_sat);
    end

    // Membrane storage: a neuron is written only when its lane block is current
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NNEU; i++) begin
                v[i] <= '0;
            end
        end else if (v_clr) begin
            for (int i = 0; i < NNEU; i++) begin
                v[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NNEU; i++) begin
                if (base == BW'(i - (i % P))) begin
                    v[i] <= lane_v[i % P];
                end
            end
        end
    end

    // Working spike bits with the current beat merged in
    always_comb begin
        work_n = work;
        if (accept) begin
            work_n[base +: P] = lane_spk;
        end
    end

    // Working register, beat base and published spike vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            base      <= '0;
            spike_opt <= '0;
        end else if (v_clr) begin
            work      <= '0;
            base      <= '0;
        end else begin
            work <= work_n;
            if (accept) begin
                base <= last_beat ? '0 : base + BASE_STEP;
            end
            if (last_beat) begin
                spike_opt <= work_n;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            ACC: begin
                if (last_beat) begin
                    state_n = OUT;
                end
            end
            OUT: begin
                if (spike_opt_valid && spike_opt_ready) begin
                    state_n = ACC;
                end
            end
            default: begin
                state_n = ACC;
            end
        endcase
        if (v_clr) begin
            state_n = ACC;
        end
    end

    // State register and handshake outputs, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ACC;
            syn_ipt_ready   <= 1'b0;
            spike_opt_valid <= 1'b0;
        end else begin
            state           <= state_n;
            syn_ipt_ready   <= (state_n == ACC);
            spike_opt_valid <= (state_n == OUT);
        end
    end

endmodule

// File: doc/lif_neuron_update.md
# lif_neuron_update

Leaky integrate-and-fire membrane stage that sits directly downstream of `synaptic_array`. It consumes the per-neuron synaptic current beats (`syn_opt`/`syn_opt_valid`/`syn_opt_ready`) and holds one signed membrane potential per neuron. Each timestep it applies leak, integration, saturation and threshold/reset. It then emits the timestep's spikes as an NNEU-bit bitmap, in the same one-hot-per-neuron format as the `sparse_bits` inputs of the next layer.

## Interface
- P, 1: neurons updated per input beat; must match `synaptic_array` P.
- MWID, 16: signed width of one synaptic current lane; MWID ≤ VWID.
- VWID, 16: signed membrane potential width.
- NNEU, 32: neurons per layer; NNEU % P == 0.
- LEAK_SHIFT, 4: leak is v >>> LEAK_SHIFT; range 1..VWID-1.
- VTH, 1024: signed firing threshold (VWID bits).
- VRST, 0: signed post-spike reset potential.
- clk  in  1  clock; all logic on rising edge. One clock domain.
- rst_n  in  1  reset; asynchronous assert, active-low.
- syn_ipt  in  P*MWID  lane j = [j*MWID +: MWID], signed current for neuron base+j.
- syn_ipt_valid  in  1  beat valid.
- syn_ipt_ready  out  1  registered; stage can accept a beat.
- v_clr  in  1  synchronous clear of all membranes and step progress.
- spike_opt  out  NNEU  bit i = neuron i fired this timestep.
- spike_opt_valid  out  1  spike vector valid.
- spike_opt_ready  in  1  downstream accepts spike vector.

## Operation
- State machine:
  - ACC: syn_ipt_ready=1. A beat is accepted when syn_ipt_valid && syn_ipt_ready.
  - OUT: syn_ipt_ready=0, spike_opt_valid=1.
- Beat counter base counts 0, P, 2P, … up to NNEU-P.
- Accepting the beat at base=NNEU-P: base wraps to 0 and the FSM moves ACC→OUT.
- OUT→ACC on spike_opt_valid && spike_opt_ready.
- Per lane j of an accepted beat, with n = base+j:
  - leak: vl = v[n] - (v[n] >>> LEAK_SHIFT), arithmetic shift, rounds toward −∞.
  - integrate: s = vl + sext(syn_ipt lane j), computed at VWID+2 bits.
  - saturate s to [−2^(VWID-1), 2^(VWID-1)−1].
  - if s ≥ VTH (signed compare): spike bit n = 1, v[n] = VRST.
  - else: bit n = 0, v[n] = s.
- Spike bits for a step accumulate in a working register. The full vector is copied to spike_opt on the ACC→OUT transition.
- spike_opt holds stable throughout OUT. The working register is fully overwritten during the next step.
- v_clr (priority over everything except reset):
  - All v = 0, base = 0, working spike bits = 0, FSM→ACC, spike_opt_valid=0.
  - A beat handshaking in the same cycle is discarded.
  - A pending spike vector is dropped.
- Neurons persist across steps. There is no implicit end-of-step leak; leak is applied only when a neuron's beat arrives.

## Timing
- Reset values: syn_ipt_ready=0, spike_opt_valid=0, spike_opt=0, all v=0, base=0, FSM=ACC.
- syn_ipt_ready rises on the first rising edge after rst_n deasserts.
- Membrane update latency: 1 cycle. v[n] is visible at the edge that accepts the beat.
- Step end: the edge accepting the last beat sets spike_opt_valid=1 and syn_ipt_ready=0 at the same edge.
- Handshake edge with spike_opt_ready=1: spike_opt_valid=0 and syn_ipt_ready=1 at that edge.
- Minimum step period: NNEU/P + 1 cycles (32 beats + 1 output cycle at defaults).
- spike_opt_ready held low: spike_opt_valid and spike_opt are stable and syn_ipt_ready stays 0 (backpressure to `synaptic_array`).
- syn_ipt_valid low: nothing changes. Gaps inside a step are legal.
- rst_n asserted mid-step: everything returns to reset values immediately. Partial step state is lost.

## Test plan
- Reset:
  - Stimulus: hold rst_n low, release.
  - Required: all outputs 0 while rst_n low; syn_ipt_ready=1 exactly one edge after release.
- Integration/leak (P=1, defaults):
  - Stimulus: neuron 0 receives 300 every step, all others 0.
  - Required: v[0] = 300, 582, 846 after steps 1–3, spike_opt=0 for those steps.
  - Required: step 4 gives s=1094 ≥ 1024, so spike_opt=32'h00000001 and v[0]=0.
- Saturation:
  - Stimulus: neuron 5 receives −32768 for 3 steps.
  - Required: v[5] = −32768 each step (−30720−32768 clamps), no spike.
  - Stimulus: +32767 one step.
  - Required: spike on bit 5, v[5]=VRST.
- Backpressure:
  - Stimulus: syn_ipt_valid held 1; spike_opt_ready=0 for 5 cycles after step end.
  - Required: spike_opt constant, spike_opt_valid=1, syn_ipt_ready=0 for all 5 cycles; no beat accepted.
  - Required: the first beat of the next step is accepted the edge after spike_opt_ready rises.
- v_clr mid-step:
  - Stimulus: assert v_clr during beat 10 with neurons pre-charged.
  - Required: beat 10 dropped, all v=0, next accepted beat maps to neuron 0, no spike_opt_valid until 32 further beats.
- Throughput:
  - Stimulus: 3 steps back-to-back, syn_ipt_valid=1, spike_opt_ready=1.
  - Required: spike_opt_valid pulses for one cycle every 33 cycles; the cross-check model matches every spike_opt.
